// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcode map, FSM state encoding and the ALU
// operation code used for address generation.
package multicycle_ctrl_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ALU  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LW   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SW   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

    // ALU code that makes the external ALU add; used for rs+imm address generation.
    localparam int unsigned ALU_ADD = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational field extraction and opcode legality check for the instruction register.
module multicycle_ctrl_instr_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RA_W    = 2,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic [DATA_W-1:0]  i_instr,
    output logic [RA_W-1:0]    o_rs,
    output logic [RA_W-1:0]    o_rt,
    output logic [RA_W-1:0]    o_rd,
    output logic [ALUOP_W-1:0] o_funct,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_is_alu,
    output logic               o_is_lw,
    output logic               o_is_sw,
    output logic               o_is_beq,
    output logic               o_is_halt,
    output logic               o_illegal
);

    localparam int unsigned RS_HI = DATA_W - OPCODE_W - 1;
    localparam int unsigned RT_HI = RS_HI - RA_W;
    localparam int unsigned RD_HI = RT_HI - RA_W;
    localparam int          GAP_HI = int'(RD_HI) - int'(RA_W);

    logic [OPCODE_W-1:0] w_opcode;

    assign w_opcode = i_instr[DATA_W-1 -: OPCODE_W];
    assign o_rs     = i_instr[RS_HI -: RA_W];
    assign o_rt     = i_instr[RT_HI -: RA_W];
    assign o_rd     = i_instr[RD_HI -: RA_W];
    assign o_funct  = i_instr[ALUOP_W-1:0];
    assign o_imm    = DATA_W'($signed(i_instr[15:0]));

    assign o_is_alu  = (w_opcode == OP_ALU);
    assign o_is_lw   = (w_opcode == OP_LW);
    assign o_is_sw   = (w_opcode == OP_SW);
    assign o_is_beq  = (w_opcode == OP_BEQ);
    assign o_is_halt = (w_opcode == OP_HALT);
    assign o_illegal = ~(o_is_alu | o_is_lw | o_is_sw | o_is_beq | o_is_halt);

    // Bits between rd and the immediate carry no meaning in this ISA.
    if (GAP_HI >= 16) begin : g_gap
        logic w_unused_gap;
        assign w_unused_gap = ^i_instr[GAP_HI:16];
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: sequences fetch/decode/execute/memory/writeback for a small ISA,
// steering an external register bank, ALU and memory.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RA_W    = 2,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [DATA_W-1:0]  pc,
    input  logic [DATA_W-1:0]  instr,
    output logic               mem_en,
    output logic               mem_rw,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               reg_we,
    output logic [RA_W-1:0]    reg_wa,
    output logic [RA_W-1:0]    reg_ra1,
    output logic [RA_W-1:0]    reg_ra2,
    output logic [DATA_W-1:0]  reg_wd,
    input  logic [DATA_W-1:0]  reg_rd1,
    input  logic [DATA_W-1:0]  reg_rd2,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [ALUOP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]  alu_y
);

    state_e r_state, w_state_nxt;

    logic [DATA_W-1:0]  r_pc, r_ir, r_a, r_b, r_result, r_addr;
    logic               r_illegal;

    logic [RA_W-1:0]    w_rs, w_rt, w_rd;
    logic [ALUOP_W-1:0] w_funct;
    logic [DATA_W-1:0]  w_imm, w_pc_inc, w_pc_br;
    logic               w_is_alu, w_is_lw, w_is_sw, w_is_beq, w_is_halt, w_illegal;

    multicycle_ctrl_instr_decode #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .ALUOP_W(ALUOP_W)
    ) u_decode (
        .i_instr  (r_ir),
        .o_rs     (w_rs),
        .o_rt     (w_rt),
        .o_rd     (w_rd),
        .o_funct  (w_funct),
        .o_imm    (w_imm),
        .o_is_alu (w_is_alu),
        .o_is_lw  (w_is_lw),
        .o_is_sw  (w_is_sw),
        .o_is_beq (w_is_beq),
        .o_is_halt(w_is_halt),
        .o_illegal(w_illegal)
    );

    assign w_pc_inc = r_pc + DATA_W'(4);
    assign w_pc_br  = w_pc_inc + (w_imm << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mem_en      = 1'b0;
        mem_rw      = 1'b0;
        mem_wdata   = '0;
        reg_we      = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        case (r_state)
            StIdle: begin
                if (start) w_state_nxt = StFetch;
            end
            StFetch: begin
                busy        = 1'b1;
                w_state_nxt = StDecode;
            end
            StDecode: begin
                busy        = 1'b1;
                w_state_nxt = (w_is_halt || w_illegal) ? StHalt : StExec;
            end
            StExec: begin
                busy  = 1'b1;
                alu_a = r_a;
                if (w_is_alu) begin
                    alu_b       = r_b;
                    alu_op      = w_funct;
                    w_state_nxt = StWb;
                end else if (w_is_lw || w_is_sw) begin
                    alu_b       = w_imm;
                    alu_op      = ALUOP_W'(ALU_ADD);
                    w_state_nxt = StMem;
                end else begin
                    w_state_nxt = StFetch;
                end
            end
            StMem: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                if (w_is_sw) begin
                    mem_rw    = 1'b1;
                    mem_wdata = r_b;
                end
                if (mem_ready) w_state_nxt = w_is_sw ? StFetch : StWb;
            end
            StWb: begin
                busy        = 1'b1;
                reg_we      = 1'b1;
                w_state_nxt = StFetch;
            end
            StHalt: begin
                w_state_nxt = StHalt;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_addr    <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) r_pc <= '0;
                end
                StFetch: begin
                    r_ir <= instr;
                end
                StDecode: begin
                    r_a <= reg_rd1;
                    r_b <= reg_rd2;
                    if (w_illegal) r_illegal <= 1'b1;
                end
                StExec: begin
                    if (w_is_alu) begin
                        r_result <= alu_y;
                    end else if (w_is_lw || w_is_sw) begin
                        r_addr <= alu_y;
                    end else if (w_is_beq) begin
                        r_pc <= (r_a == r_b) ? w_pc_br : w_pc_inc;
                    end
                end
                StMem: begin
                    // Loads advance pc in writeback, stores at transfer completion.
                    if (mem_ready) begin
                        if (w_is_sw) r_pc <= w_pc_inc;
                        else         r_result <= mem_rdata;
                    end
                end
                StWb: begin
                    r_pc <= w_pc_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign halted   = (r_state == StHalt);
    assign illegal  = r_illegal;
    assign pc       = r_pc;
    assign mem_addr = r_addr;
    assign reg_ra1  = w_rs;
    assign reg_ra2  = w_rt;
    assign reg_wa   = w_rd;
    assign reg_wd   = r_result;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an ISA-level model expands each instruction into
// per-cycle expected outputs; directed programs plus literal checks pin the model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        busy;
        logic        halted;
        logic        illegal;
        logic [31:0] pc;
        logic        mem_en;
        logic        mem_rw;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        reg_we;
        logic [1:0]  reg_wa;
        logic [31:0] reg_wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        busy, halted, illegal;
    logic [31:0] pc, instr;
    logic        mem_en, mem_rw, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        reg_we;
    logic [1:0]  reg_wa, reg_ra1, reg_ra2;
    logic [31:0] reg_wd, reg_rd1, reg_rd2;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;

    // Environment (register bank, memories, wait-state generator) and model state.
    logic [31:0] rf [4];
    logic [31:0] m_rf [4];
    logic [31:0] dmem [256];
    logic [31:0] m_mem [256];
    logic [31:0] imem [64];
    int          wait_cfg, cnt, cyc, first_we, first_halt, we_cnt, en_cycles, wr_cnt;
    logic        en_seen, rdy_seen;

    exp_t        exp_q [1024];
    int          exp_wr = 0;
    int          exp_rd = 0;
    string       lit_name [128];
    logic [31:0] lit_act [128];
    logic [31:0] lit_exp [128];
    int          lit_wr = 0;
    int          lit_rd = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        e;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .DATA_W (32),
        .RA_W   (2),
        .ALUOP_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .pc       (pc),
        .instr    (instr),
        .mem_en   (mem_en),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .reg_we   (reg_we),
        .reg_wa   (reg_wa),
        .reg_ra1  (reg_ra1),
        .reg_ra2  (reg_ra2),
        .reg_wd   (reg_wd),
        .reg_rd1  (reg_rd1),
        .reg_rd2  (reg_rd2),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_y    (alu_y)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [1:0] rd,
                                        input logic [15:0] lo);
        return {op, rs, rt, rd, 6'd0, lo};
    endfunction

    assign instr     = imem[pc[7:2]];
    assign reg_rd1   = rf[reg_ra1];
    assign reg_rd2   = rf[reg_ra2];
    assign alu_y     = alu_fn(alu_op, alu_a, alu_b);
    assign mem_rdata = dmem[mem_addr[9:2]];
    assign mem_ready = mem_en && (cnt == wait_cfg);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, want, $time);
        end
    endtask

    // Sole checker: drains literal expectations, then one model record per cycle.
    always @(negedge clk) begin
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
        if (exp_rd < exp_wr) begin
            e = exp_q[exp_rd];
            chk($sformatf("rec%0d.busy", exp_rd), 32'(busy), 32'(e.busy));
            chk($sformatf("rec%0d.halted", exp_rd), 32'(halted), 32'(e.halted));
            chk($sformatf("rec%0d.illegal", exp_rd), 32'(illegal), 32'(e.illegal));
            chk($sformatf("rec%0d.pc", exp_rd), pc, e.pc);
            chk($sformatf("rec%0d.mem_en", exp_rd), 32'(mem_en), 32'(e.mem_en));
            chk($sformatf("rec%0d.mem_rw", exp_rd), 32'(mem_rw), 32'(e.mem_rw));
            chk($sformatf("rec%0d.reg_we", exp_rd), 32'(reg_we), 32'(e.reg_we));
            if (e.mem_en) chk($sformatf("rec%0d.mem_addr", exp_rd), mem_addr, e.mem_addr);
            if (e.mem_rw) chk($sformatf("rec%0d.mem_wdata", exp_rd), mem_wdata, e.mem_wdata);
            if (e.reg_we) begin
                chk($sformatf("rec%0d.reg_wa", exp_rd), 32'(reg_wa), 32'(e.reg_wa));
                chk($sformatf("rec%0d.reg_wd", exp_rd), reg_wd, e.reg_wd);
            end
            exp_rd++;
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
        lit_name[lit_wr] = nm;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = want;
        lit_wr++;
    endtask

    task automatic push(input exp_t r, inout int n);
        exp_q[exp_wr + n] = r;
        n++;
    endtask

    // ISA-level model: run instructions, emitting the cycle-by-cycle outputs implied by the
    // CPI table (fetch/decode/exec, then memory and/or writeback) without committing them.
    task automatic gen(input int max_ins, output int n);
        logic [31:0] mpc, ins, a, b, imm, ea, res;
        logic [3:0]  op;
        logic [1:0]  rs, rt, rd;
        exp_t        p, r;
        logic        done;
        n    = 0;
        mpc  = 32'd0;
        done = 1'b0;
        for (int k = 0; k < max_ins && !done; k++) begin
            ins = imem[mpc[7:2]];
            op  = ins[31:28];
            rs  = ins[27:26];
            rt  = ins[25:24];
            rd  = ins[23:22];
            imm = {{16{ins[15]}}, ins[15:0]};
            a   = m_rf[rs];
            b   = m_rf[rt];
            p        = '0;
            p.busy   = 1'b1;
            p.pc     = mpc;
            if (op > 4'h3) begin
                push(p, n);
                push(p, n);
                r         = '0;
                r.halted  = 1'b1;
                r.illegal = (op != 4'hF);
                r.pc      = mpc;
                push(r, n);
                push(r, n);
                done = 1'b1;
            end else begin
                for (int j = 0; j < 3; j++) push(p, n);
                r = p;
                case (op)
                    4'h0: begin
                        res      = alu_fn(ins[3:0], a, b);
                        r.reg_we = 1'b1;
                        r.reg_wa = rd;
                        r.reg_wd = res;
                        push(r, n);
                        m_rf[rd] = res;
                        mpc      = mpc + 32'd4;
                    end
                    4'h1, 4'h2: begin
                        ea         = a + imm;
                        r.mem_en   = 1'b1;
                        r.mem_addr = ea;
                        r.mem_rw   = (op == 4'h2);
                        r.mem_wdata = b;
                        for (int j = 0; j <= wait_cfg; j++) push(r, n);
                        if (op == 4'h1) begin
                            r          = p;
                            r.reg_we   = 1'b1;
                            r.reg_wa   = rd;
                            r.reg_wd   = m_mem[ea[9:2]];
                            push(r, n);
                            m_rf[rd]   = m_mem[ea[9:2]];
                        end else begin
                            m_mem[ea[9:2]] = b;
                        end
                        mpc = mpc + 32'd4;
                    end
                    default: begin
                        mpc = (a == b) ? mpc + 32'd4 + (imm << 2) : mpc + 32'd4;
                    end
                endcase
            end
        end
    endtask

    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        cnt = 0; cyc = 0; first_we = 0; first_halt = 0;
        we_cnt = 0; en_cycles = 0; wr_cnt = 0; wait_cfg = 0;
        en_seen = 1'b0; rdy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin rf[i] = '0; m_rf[i] = '0; end
        for (int i = 0; i < 256; i++) begin dmem[i] = '0; m_mem[i] = '0; end
        for (int i = 0; i < 64; i++) imem[i] = enc(4'hF, 2'd0, 2'd0, 2'd0, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        rf[i]   = v;
        m_rf[i] = v;
    endtask

    task automatic set_mem(input logic [31:0] addr, input logic [31:0] v);
        dmem[addr[9:2]]  = v;
        m_mem[addr[9:2]] = v;
    endtask

    task automatic run_env(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cyc++;
            if (reg_we) begin
                rf[reg_wa] = reg_wd;
                we_cnt++;
                if (first_we == 0) first_we = cyc;
            end
            if (mem_en) en_cycles++;
            if (mem_en && mem_rw && mem_ready) begin
                dmem[mem_addr[9:2]] = mem_wdata;
                wr_cnt++;
            end
            if (halted && first_halt == 0) first_halt = cyc;
            en_seen  = mem_en;
            rdy_seen = mem_ready;
            @(posedge clk);
            #1;
            cnt = (en_seen && !rdy_seen) ? cnt + 1 : 0;
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_prog(input int max_ins);
        int n;
        gen(max_ins, n);
        kick();
        exp_wr = exp_wr + n;
        run_env(n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;

        // ALU r1 = r2 + r3, then HALT.
        reset_dut();
        #1;
        lit("rst.busy", 32'(busy), 32'd0);
        lit("rst.halted", 32'(halted), 32'd0);
        lit("rst.illegal", 32'(illegal), 32'd0);
        lit("rst.pc", pc, 32'd0);
        lit("rst.strobes", {29'd0, mem_en, mem_rw, reg_we}, 32'd0);
        set_reg(2, 32'd5);
        set_reg(3, 32'd7);
        imem[0] = enc(4'h0, 2'd2, 2'd3, 2'd1, 16'd0);
        imem[1] = enc(4'hF, 2'd0, 2'd0, 2'd0, 16'd0);
        run_prog(4);
        lit("alu.r1", rf[1], 32'd12);
        lit("alu.model_r1", m_rf[1], 32'd12);
        lit("alu.we_cycle", 32'(first_we), 32'd4);
        lit("alu.halt_cycle", 32'(first_halt), 32'd7);
        lit("alu.halted", 32'(halted), 32'd1);

        // Start is ignored once halted.
        start = 1'b1;
        run_env(2);
        start = 1'b0;
        lit("halt.sticky", {30'd0, halted, busy}, 32'd2);

        // SW r2 -> [r1+8] with three wait states.
        reset_dut();
        set_reg(1, 32'h100);
        set_reg(2, 32'hAB);
        wait_cfg = 3;
        imem[0] = enc(4'h2, 2'd1, 2'd2, 2'd0, 16'd8);
        run_prog(4);
        lit("sw.mem108", dmem[32'h108 >> 2], 32'hAB);
        lit("sw.writes", 32'(wr_cnt), 32'd1);
        lit("sw.en_cycles", 32'(en_cycles), 32'd4);
        lit("sw.halt_pc", pc, 32'd4);

        // LW r3 <= mem[0x10].
        reset_dut();
        set_mem(32'h10, 32'hDEADBEEF);
        imem[0] = enc(4'h1, 2'd0, 2'd0, 2'd3, 16'h0010);
        run_prog(4);
        lit("lw.r3", rf[3], 32'hDEADBEEF);
        lit("lw.we_cycle", 32'(first_we), 32'd5);
        lit("lw.pc", pc, 32'd4);

        // BEQ taken with imm=-1 spins at 0x20.
        reset_dut();
        set_reg(1, 32'd9);
        set_reg(2, 32'd9);
        imem[0] = enc(4'h3, 2'd0, 2'd0, 2'd0, 16'd7);
        imem[8] = enc(4'h3, 2'd1, 2'd2, 2'd0, 16'hFFFF);
        run_prog(3);
        lit("beq_t.pc", pc, 32'h20);
        lit("beq_t.busy", 32'(busy), 32'd1);

        // BEQ not taken at 0x20 falls through to 0x24.
        reset_dut();
        set_reg(1, 32'd1);
        set_reg(2, 32'd2);
        imem[0] = enc(4'h3, 2'd0, 2'd0, 2'd0, 16'd7);
        imem[8] = enc(4'h3, 2'd1, 2'd2, 2'd0, 16'hFFFF);
        run_prog(4);
        lit("beq_n.pc", pc, 32'h24);
        lit("beq_n.halted", 32'(halted), 32'd1);

        // Mixed program: sub, or, store, load, taken branch skipping one instruction.
        reset_dut();
        set_reg(1, 32'h30);
        set_reg(2, 32'h0F);
        wait_cfg = 2;
        imem[0] = enc(4'h0, 2'd1, 2'd2, 2'd3, 16'd1);
        imem[1] = enc(4'h0, 2'd1, 2'd2, 2'd0, 16'd3);
        imem[2] = enc(4'h2, 2'd1, 2'd3, 2'd0, 16'd4);
        imem[3] = enc(4'h1, 2'd1, 2'd0, 2'd2, 16'd4);
        imem[4] = enc(4'h3, 2'd2, 2'd3, 2'd0, 16'd1);
        imem[5] = enc(4'h0, 2'd0, 2'd0, 2'd0, 16'd4);
        run_prog(10);
        lit("mix.r3", rf[3], 32'h21);
        lit("mix.r0", rf[0], 32'h3F);
        lit("mix.r2", rf[2], 32'h21);
        lit("mix.mem34", dmem[32'h34 >> 2], 32'h21);
        lit("mix.pc", pc, 32'h18);

        // Illegal opcode 0x7.
        reset_dut();
        imem[0] = enc(4'h7, 2'd0, 2'd0, 2'd0, 16'd0);
        run_prog(2);
        lit("ill.flags", {29'd0, illegal, halted, busy}, 32'd6);
        lit("ill.strobes", 32'(we_cnt + en_cycles), 32'd0);
        reset_dut();
        #1;
        lit("ill.cleared", {30'd0, illegal, halted}, 32'd0);

        // Reset during a stalled store aborts it.
        reset_dut();
        set_reg(1, 32'h100);
        set_reg(2, 32'h55);
        wait_cfg = 10;
        imem[0] = enc(4'h2, 2'd1, 2'd2, 2'd0, 16'd0);
        kick();
        run_env(6);
        lit("abort.en_cycles", 32'(en_cycles), 32'd3);
        lit("abort.addr", mem_addr, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        lit("abort.mem_en", 32'(mem_en), 32'd0);
        lit("abort.busy_pc", {31'd0, busy} | pc, 32'd0);
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_env(10);
        lit("abort.writes", 32'(wr_cnt), 32'd0);
        lit("abort.en_after", 32'(en_cycles), 32'd3);
        lit("abort.mem100", dmem[32'h100 >> 2], 32'd0);

        for (int i = 0; i < 20 && (lit_rd < lit_wr || exp_rd < exp_wr); i++) begin
            @(negedge clk);
            #1;
        end
        if (lit_rd < lit_wr || exp_rd < exp_wr) begin
            $display("FAIL drain: checker still has %0d pending, want 0",
                     (lit_wr - lit_rd) + (exp_wr - exp_rd));
            $fatal(1, "checker did not drain");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
